mem_loader: RTL
===============

# mem_loader

Boot-time program loader acting as master1 of the memory store/load bus. Accepts a byte stream (e.g. from a UART receiver), packs four bytes into a word, and writes each word to sequential memory addresses through the bus's master1 port, optionally reading each word back to verify it. Master0 (the core's execute/control path) always has priority on the bus. The loader holds the core off with `cpu_hold` while a session is active.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, 1024: the session ends automatically after this many words have been written.
- `VERIFY`, 1: 1 enables a read-back compare after every write; 0 skips it.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a session; honoured only in IDLE or DONE.
- `finish`  in  1  one-cycle pulse that ends the session; any partial word is flushed first.
- `rx_valid`  in  1  a byte is offered on `rx_data`.
- `rx_data`  in  8  byte payload.
- `rx_ready`  out  1  the loader accepts a byte this cycle.
- `m0_busy`  in  1  master0 is using the bus (`m0_re | m0_we`); the loader must not issue while it is high.
- `m1_un_sign`  out  1  constant 0.
- `m1_byte_mask`  out  4  4'b1111 in WRITE and VERIFY, otherwise 0.
- `m1_re`, `m1_we`  out  1 each  bus read and write strobes.
- `m1_addr`  out  32  current word address.
- `m1_wdata`  out  32  assembled word; the first received byte occupies bits [7:0].
- `m1_rdata`  in  32  read data returned by the bus, valid in the same cycle as `m1_re` (memory read is combinational).
- `cpu_hold`  out  1  high while the state is COLLECT, WRITE or VERIFY.
- `done`  out  1  level signal, high in the DONE state.
- `err`  out  1  sticky verify-mismatch flag; cleared by `start`.
- `word_cnt`  out  16  number of words committed in the current session.

## Operation
- **States:** IDLE, COLLECT, WRITE, VERIFY, DONE.
- **IDLE / DONE + `start`:**
  - load `addr` with `BASE_ADDR`;
  - clear `byte_idx`, `word`, `word_cnt`, `err` and `last`;
  - go to COLLECT.
- **COLLECT:**
  - `rx_ready`=1.
  - On `rx_valid`, write `rx_data` into `word[8*byte_idx +: 8]` and increment `byte_idx`.
  - When the accepted byte is the 4th (`byte_idx`==3), go to WRITE.
- **`finish` in COLLECT:**
  - If a byte is accepted in the same cycle, that byte is stored first.
  - Set `last`.
  - If the post-accept byte count is non-zero, go to WRITE (unfilled lanes stay zero). Otherwise go to DONE.
- **`finish` outside COLLECT:** ignored.
- **WRITE:**
  - `rx_ready`=0.
  - `m1_we` = ~`m0_busy`.
  - When the write is issued: if `VERIFY`=1 go to VERIFY; otherwise commit.
- **VERIFY:**
  - `m1_re` = ~`m0_busy`.
  - When the read is issued, compare `m1_rdata` with `word`.
  - On mismatch, set `err` and go to DONE; `addr` and `word_cnt` are not advanced.
  - On match, commit.
- **Commit:**
  - `addr` += 4; `word_cnt` += 1; clear `word` and `byte_idx`.
  - Go to DONE if `last` is set or the new `word_cnt` equals `MAX_WORDS`; otherwise go to COLLECT.
- **DONE:** `rx_ready`=0, `cpu_hold`=0, `done`=1. Any bytes offered are not accepted.
- **`start` in COLLECT, WRITE or VERIFY:** ignored.
- **Width rules:** `addr` wraps modulo 2^32. `word_cnt` is compared against `MAX_WORDS` at full 16-bit width.

## Timing
- **Reset values:** all outputs 0; state IDLE; `addr`=`BASE_ADDR`. Reset asserted mid-session aborts immediately and discards any partial word.
- **Output decode:**
  - `m1_we`/`m1_re` are combinational from state and `m0_busy`.
  - `m1_addr`/`m1_wdata` come directly from registers.
- **Throughput:** at most one byte per cycle.
- **Uncontended word cost:** 4 COLLECT cycles + 1 WRITE cycle + 1 VERIFY cycle (VERIFY only when `VERIFY`=1).
- **Contention:** each cycle of `m0_busy` in WRITE or VERIFY adds exactly one stall cycle. Strobes are never asserted while `m0_busy` is high.
- **`done` latency:** `done` rises the cycle after the final commit, or the cycle after `finish` when no bytes are pending.

## Structure
- Shared `defines.v` gains the loader state encodings (`LD_IDLE` .. `LD_DONE`) and `WORD_MASK_ALL` (4'b1111).
- Reuses the existing `ZERO32`, `BYTE_SEL` and `MEM_ADDR_WIDTH` definitions.
- Single flat module. A `byte_packer` sub-module (byte lane select plus counter) is the only natural split; it is optional.

## Test plan
- `start`, then bytes 01..08 with `m0_busy`=0 and `VERIFY`=1 → writes of 32'h04030201 @0x0 and 32'h08070605 @0x4. Then `finish` → `word_cnt`=2, `done`=1, `err`=0.
- Bytes 01..06, then `finish` → second write 32'h0000_0605 @0x4, followed by `done`.
- `m0_busy` held high for 5 cycles after entering WRITE → `m1_we`=0 and `rx_ready`=0 for those 5 cycles; the write issues in the cycle `m0_busy` falls.
- Memory model corrupts the read-back of word 1 → `err`=1, `done`=1, `word_cnt`=1, no further writes.
- `MAX_WORDS`=2 with 12 bytes offered → exactly 2 writes; `done`=1 after byte 8; bytes 9..12 are never accepted.
- `rst` driven low mid-COLLECT → all outputs 0 immediately. A following `start` writes its first word at `BASE_ADDR` with `word_cnt`=0.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by the loader top and its byte packer.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COLLECT,
        LD_WRITE,
        LD_VERIFY,
        LD_DONE
    } ld_state_e;

    localparam logic [3:0]  WORD_MASK_ALL  = 4'b1111;
    localparam logic [31:0] ZERO32         = 32'h0000_0000;
    localparam int          MEM_ADDR_WIDTH = 32;

    // Bit offset of a byte lane inside a 32-bit word.
    function automatic logic [4:0] byte_sel(input logic [1:0] idx);
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Byte-lane packer: places incoming bytes little-endian into a word
// and tracks how many lanes of the current word are filled.
module mem_loader_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  idx_o,
    output logic        full_o,
    output logic        pending_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= ZERO32;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            word_d = ZERO32;
            idx_d  = 2'd0;
        end else if (push_i) begin
            word_d[byte_sel(idx_q) +: 8] = byte_i;
            idx_d  = idx_q + 2'd1;
        end
    end

    // pending_o: lane count after this cycle's push is non-zero
    assign full_o    = push_i && (idx_q == 2'd3);
    assign pending_o = push_i || (idx_q != 2'd0);
    assign word_o    = word_q;
    assign idx_o     = idx_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: packs a byte stream into words and writes them through
// bus master1, optionally reading each word back to verify it.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        finish,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        m0_busy,
    output logic        m1_un_sign,
    output logic [3:0]  m1_byte_mask,
    output logic        m1_re,
    output logic        m1_we,
    output logic [31:0] m1_addr,
    output logic [31:0] m1_wdata,
    input  logic [31:0] m1_rdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    ld_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        last_q, last_d;

    logic        accept;
    logic        clr;
    logic        commit;
    logic        full;
    logic        pending;
    logic [1:0]  idx;
    logic [31:0] word;
    logic [15:0] cnt_inc;

    assign accept  = rx_valid && (state_q == LD_COLLECT);
    assign cnt_inc = cnt_q + 16'd1;

    mem_loader_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .push_i    (accept),
        .byte_i    (rx_data),
        .word_o    (word),
        .idx_o     (idx),
        .full_o    (full),
        .pending_o (pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            addr_q  <= BASE_ADDR;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        last_d  = last_q;
        clr     = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    state_d = LD_COLLECT;
                    addr_d  = BASE_ADDR;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    last_d  = 1'b0;
                    clr     = 1'b1;
                end
            end
            LD_COLLECT: begin
                if (full) begin
                    state_d = LD_WRITE;
                end
                if (finish) begin
                    last_d  = 1'b1;
                    state_d = pending ? LD_WRITE : LD_DONE;
                end
            end
            LD_WRITE: begin
                if (!m0_busy) begin
                    if (VERIFY) begin
                        state_d = LD_VERIFY;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            LD_VERIFY: begin
                if (!m0_busy) begin
                    if (m1_rdata != word) begin
                        err_d   = 1'b1;
                        state_d = LD_DONE;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
        // A committed word advances the address and may end the session.
        if (commit) begin
            addr_d  = addr_q + 32'd4;
            cnt_d   = cnt_inc;
            clr     = 1'b1;
            state_d = (last_q || cnt_inc == MAX_CNT)
                    ? LD_DONE : LD_COLLECT;
        end
    end

    always_comb begin
        rx_ready     = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        m1_we        = 1'b0;
        m1_re        = 1'b0;
        m1_byte_mask = 4'b0000;
        unique case (state_q)
            LD_COLLECT: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            LD_WRITE: begin
                cpu_hold     = 1'b1;
                m1_byte_mask = WORD_MASK_ALL;
                m1_we        = ~m0_busy;
            end
            LD_VERIFY: begin
                cpu_hold     = 1'b1;
                m1_byte_mask = WORD_MASK_ALL;
                m1_re        = ~m0_busy;
            end
            LD_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign m1_un_sign = 1'b0;
    assign m1_addr    = addr_q;
    assign m1_wdata   = word;
    assign err        = err_q;
    assign word_cnt   = cnt_q;

endmodule
